// File: rtl/lc3_pipeline_ctrl.sv
// Control sequencer for the 5-stage LC3 pipeline: stage enables, operand bypass,
// data-memory handshake state and branch flush.
module lc3_pipeline_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_complete_instr,
  input  logic        i_complete_data,
  input  logic [15:0] i_ir,
  input  logic [15:0] i_ir_exec,
  input  logic [2:0]  i_psr,
  output logic        o_enable_updatePC,
  output logic        o_enable_fetch,
  output logic        o_enable_decode,
  output logic        o_enable_execute,
  output logic        o_enable_writeback,
  output logic        o_bypass_alu_1,
  output logic        o_bypass_alu_2,
  output logic        o_bypass_mem_1,
  output logic        o_bypass_mem_2,
  output logic [1:0]  o_mem_state,
  output logic        o_br_taken
);

  localparam logic [2:0] S_FILL  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_STALL = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  localparam logic [1:0] MS_READ  = 2'b00;
  localparam logic [1:0] MS_IND   = 2'b01;
  localparam logic [1:0] MS_WRITE = 2'b10;
  localparam logic [1:0] MS_IDLE  = 2'b11;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  logic [2:0] r_state;
  logic [1:0] r_fill_cnt;
  logic [2:0] r_flush_cnt;
  logic       r_is_load;
  logic       r_en_pc, r_en_fetch, r_en_dec, r_en_exe, r_en_wb;
  logic [1:0] r_mem_state;
  logic       r_br;

  logic [3:0] w_ex_op, w_id_op;
  logic       w_ex_alu, w_ex_lea, w_ex_load, w_ex_store, w_ex_ind, w_ex_taken;
  logic       w_id_alu, w_src1_hit, w_src2_hit, w_byp_en, w_wb_rule;
  logic       w_unused;

  assign w_ex_op    = i_ir_exec[15:12];
  assign w_id_op    = i_ir[15:12];
  assign w_ex_alu   = (w_ex_op == 4'b0001) || (w_ex_op == 4'b0101) || (w_ex_op == 4'b1001);
  assign w_ex_lea   = (w_ex_op == 4'b1110);
  assign w_ex_load  = (w_ex_op == 4'b0010) || (w_ex_op == 4'b0110) || (w_ex_op == 4'b1010);
  assign w_ex_store = (w_ex_op == 4'b0011) || (w_ex_op == 4'b0111) || (w_ex_op == 4'b1011);
  assign w_ex_ind   = (w_ex_op == 4'b1010) || (w_ex_op == 4'b1011);
  assign w_ex_taken = (w_ex_op == 4'b1100) ||
                      ((w_ex_op == 4'b0000) && ((i_ir_exec[11:9] & i_psr) != 3'b000));
  assign w_wb_rule  = r_en_exe && (w_ex_alu || w_ex_lea || w_ex_load);

  // Forwarding compares decode-stage sources against the execute-stage DR
  assign w_id_alu   = (w_id_op == 4'b0001) || (w_id_op == 4'b0101) || (w_id_op == 4'b1001);
  assign w_src1_hit = (w_id_alu || (w_id_op == 4'b0110) || (w_id_op == 4'b0111) ||
                       (w_id_op == 4'b1100)) && (i_ir[8:6] == i_ir_exec[11:9]);
  assign w_src2_hit = ((w_id_op == 4'b0001) || (w_id_op == 4'b0101)) && !i_ir[5] &&
                      (i_ir[2:0] == i_ir_exec[11:9]);
  assign w_byp_en   = (r_state == S_RUN) && r_en_exe;

  assign o_bypass_alu_1 = w_byp_en && w_src1_hit && (w_ex_alu || w_ex_lea);
  assign o_bypass_alu_2 = w_byp_en && w_src2_hit && (w_ex_alu || w_ex_lea);
  assign o_bypass_mem_1 = w_byp_en && w_src1_hit && w_ex_load;
  assign o_bypass_mem_2 = w_byp_en && w_src2_hit && w_ex_load;

  assign w_unused = ^{i_ir[11:9], i_ir[4:3], i_ir_exec[8:0]};

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_FILL;
      r_fill_cnt  <= 2'd0;
      r_flush_cnt <= 3'd0;
      r_is_load   <= 1'b0;
      r_en_pc     <= 1'b0;
      r_en_fetch  <= 1'b0;
      r_en_dec    <= 1'b0;
      r_en_exe    <= 1'b0;
      r_en_wb     <= 1'b0;
      r_mem_state <= MS_IDLE;
      r_br        <= 1'b0;
    end else begin
      r_br <= 1'b0;
      case (r_state)
        S_FILL: begin
          r_fill_cnt <= r_fill_cnt + 2'd1;
          case (r_fill_cnt)
            2'd0: begin
              r_en_pc    <= 1'b1;
              r_en_fetch <= 1'b1;
            end
            2'd1: r_en_dec <= 1'b1;
            2'd2: r_en_exe <= 1'b1;
            default: begin
              r_en_wb <= w_wb_rule;
              r_state <= S_RUN;
            end
          endcase
        end
        S_RUN: begin
          if (r_en_exe && (w_ex_load || w_ex_store)) begin
            r_state     <= S_MEM;
            r_is_load   <= w_ex_load;
            r_mem_state <= w_ex_ind ? MS_IND : (w_ex_load ? MS_READ : MS_WRITE);
            r_en_pc     <= 1'b0;
            r_en_fetch  <= 1'b0;
            r_en_dec    <= 1'b0;
            r_en_exe    <= 1'b0;
            r_en_wb     <= 1'b0;
          end else if (r_en_exe && w_ex_taken) begin
            r_state     <= S_FLUSH;
            r_flush_cnt <= FLUSH_INIT;
            r_br        <= 1'b1;
            r_en_dec    <= 1'b0;
            r_en_exe    <= 1'b0;
            r_en_wb     <= 1'b0;
          end else begin
            r_state    <= i_complete_instr ? S_RUN : S_STALL;
            r_en_pc    <= i_complete_instr;
            r_en_fetch <= i_complete_instr;
            r_en_dec   <= i_complete_instr;
            r_en_exe   <= i_complete_instr;
            r_en_wb    <= i_complete_instr && w_wb_rule;
          end
        end
        S_STALL: begin
          r_en_wb <= 1'b0;
          if (i_complete_instr) begin
            r_state    <= S_RUN;
            r_en_pc    <= 1'b1;
            r_en_fetch <= 1'b1;
            r_en_dec   <= 1'b1;
            r_en_exe   <= 1'b1;
          end
        end
        S_MEM: begin
          if (i_complete_data) begin
            if (r_mem_state == MS_IND) begin
              r_mem_state <= r_is_load ? MS_READ : MS_WRITE;
            end else begin
              // The load retires even if the fetch side is stalled on exit
              r_mem_state <= MS_IDLE;
              r_en_wb     <= r_is_load;
              r_state     <= i_complete_instr ? S_RUN : S_STALL;
              r_en_pc     <= i_complete_instr;
              r_en_fetch  <= i_complete_instr;
              r_en_dec    <= i_complete_instr;
              r_en_exe    <= i_complete_instr;
            end
          end
        end
        S_FLUSH: begin
          r_en_wb <= 1'b0;
          if (r_flush_cnt <= 3'd1) begin
            r_state    <= i_complete_instr ? S_RUN : S_STALL;
            r_en_pc    <= i_complete_instr;
            r_en_fetch <= i_complete_instr;
            r_en_dec   <= i_complete_instr;
            r_en_exe   <= i_complete_instr;
          end else begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign o_enable_updatePC  = r_en_pc;
  assign o_enable_fetch     = r_en_fetch;
  assign o_enable_decode    = r_en_dec;
  assign o_enable_execute   = r_en_exe;
  assign o_enable_writeback = r_en_wb;
  assign o_mem_state        = r_mem_state;
  assign o_br_taken         = r_br;

endmodule

// File: tb/tb_lc3_pipeline_ctrl.sv
// Scenario bench for lc3_pipeline_ctrl: expected output vectors are queued as
// stimulus is driven and popped for comparison one edge later.
module tb_lc3_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ci = 1'b1;
  logic        cd = 1'b0;
  logic [15:0] ir = 16'h0000;
  logic [15:0] ir_exec = 16'h0000;
  logic [2:0]  psr = 3'b000;

  logic o_pc, o_fetch, o_dec, o_exe, o_wb;
  logic o_alu1, o_alu2, o_mem1, o_mem2, o_br;
  logic [1:0] o_ms;

  lc3_pipeline_ctrl #(.FLUSH_CYCLES(2)) dut (
    .i_clock           (clk),
    .i_reset_n         (rst_n),
    .i_complete_instr  (ci),
    .i_complete_data   (cd),
    .i_ir              (ir),
    .i_ir_exec         (ir_exec),
    .i_psr             (psr),
    .o_enable_updatePC (o_pc),
    .o_enable_fetch    (o_fetch),
    .o_enable_decode   (o_dec),
    .o_enable_execute  (o_exe),
    .o_enable_writeback(o_wb),
    .o_bypass_alu_1    (o_alu1),
    .o_bypass_alu_2    (o_alu2),
    .o_bypass_mem_1    (o_mem1),
    .o_bypass_mem_2    (o_mem2),
    .o_mem_state       (o_ms),
    .o_br_taken        (o_br)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];
  logic [3:0] byp_q[$];

  // Expected vector layout: {updatePC, fetch, decode, execute, writeback, mem_state[1:0], br_taken}
  typedef struct packed {
    logic [15:0] ie;
    logic [2:0]  psr;
    logic        ci;
    logic        cd;
    logic [7:0]  exp;
  } step_t;

  function automatic logic [7:0] outs();
    return {o_pc, o_fetch, o_dec, o_exe, o_wb, o_ms, o_br};
  endfunction

  function automatic logic [3:0] byp();
    return {o_alu1, o_alu2, o_mem1, o_mem2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e, a;
    logic [3:0] eb, ab;
    rst_n = 1'b0; ci = 1'b1; cd = 1'b0; psr = 3'b000;
    ir = 16'h1443; ir_exec = 16'h1261;
    exp_q.push_back(8'b0000_0110);
    byp_q.push_back(4'b0000);
    tick(); tick();
    e = exp_q.pop_front(); a = outs(); n_total++;
    if (a !== e) $display("FAIL reset outs=%b required=%b", a, e);
    else begin n_pass++; $display("reset outs=%b", a); end
    eb = byp_q.pop_front(); ab = byp(); n_total++;
    if (ab !== eb) $display("FAIL reset_bypass byp=%b required=%b", ab, eb);
    else begin n_pass++; $display("reset_bypass byp=%b", ab); end
    ir = 16'h0000; ir_exec = 16'h0000;
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [7:0] e, a;
    step_t s [5] = '{
      '{16'h0000, 3'b000, 1'b1, 1'b0, 8'b1100_0110},
      '{16'h0000, 3'b000, 1'b1, 1'b0, 8'b1110_0110},
      '{16'h0000, 3'b000, 1'b1, 1'b0, 8'b1111_0110},
      '{16'h0000, 3'b000, 1'b1, 1'b0, 8'b1111_0110},
      '{16'h0000, 3'b000, 1'b1, 1'b0, 8'b1111_0110}
    };
    for (int i = 0; i < 5; i++) begin
      ir_exec = s[i].ie; psr = s[i].psr; ci = s[i].ci; cd = s[i].cd;
      exp_q.push_back(s[i].exp);
      tick();
      e = exp_q.pop_front(); a = outs(); n_total++;
      if (a !== e) $display("FAIL fill[%0d] outs=%b required=%b", i, a, e);
      else begin n_pass++; $display("fill[%0d] outs=%b", i, a); end
    end
  endtask

  task automatic test_ldr();
    logic [7:0] e, a;
    step_t s [7] = '{
      '{16'h6283, 3'b000, 1'b0, 1'b0, 8'b0000_0000},
      '{16'h0000, 3'b000, 1'b0, 1'b0, 8'b0000_0000},
      '{16'h0000, 3'b000, 1'b0, 1'b0, 8'b0000_0000},
      '{16'h0000, 3'b000, 1'b0, 1'b0, 8'b0000_0000},
      '{16'h0000, 3'b000, 1'b1, 1'b1, 8'b1111_1110},
      '{16'h0000, 3'b000, 1'b1, 1'b1, 8'b1111_0110},
      '{16'h0000, 3'b000, 1'b1, 1'b0, 8'b1111_0110}
    };
    for (int i = 0; i < 7; i++) begin
      ir_exec = s[i].ie; psr = s[i].psr; ci = s[i].ci; cd = s[i].cd;
      exp_q.push_back(s[i].exp);
      tick();
      e = exp_q.pop_front(); a = outs(); n_total++;
      if (a !== e) $display("FAIL ldr[%0d] outs=%b required=%b", i, a, e);
      else begin n_pass++; $display("ldr[%0d] outs=%b", i, a); end
    end
  endtask

  task automatic test_sti();
    logic [7:0] e, a;
    step_t s [6] = '{
      '{16'hB405, 3'b000, 1'b1, 1'b0, 8'b0000_0010},
      '{16'h0000, 3'b000, 1'b1, 1'b0, 8'b0000_0010},
      '{16'h0000, 3'b000, 1'b1, 1'b1, 8'b0000_0100},
      '{16'h0000, 3'b000, 1'b1, 1'b0, 8'b0000_0100},
      '{16'h0000, 3'b000, 1'b1, 1'b1, 8'b1111_0110},
      '{16'h0000, 3'b000, 1'b1, 1'b0, 8'b1111_0110}
    };
    for (int i = 0; i < 6; i++) begin
      ir_exec = s[i].ie; psr = s[i].psr; ci = s[i].ci; cd = s[i].cd;
      exp_q.push_back(s[i].exp);
      tick();
      e = exp_q.pop_front(); a = outs(); n_total++;
      if (a !== e) $display("FAIL sti[%0d] outs=%b required=%b", i, a, e);
      else begin n_pass++; $display("sti[%0d] outs=%b", i, a); end
    end
  endtask

  task automatic test_bypass();
    logic [7:0] e, a;
    logic [3:0] eb, ab;
    logic [15:0] ie_tab [5] = '{16'h1261, 16'h1261, 16'h1261, 16'h6283, 16'h6283};
    logic [15:0] ir_tab [5] = '{16'h1443, 16'h14C1, 16'h14E1, 16'h1443, 16'h14C1};
    logic [3:0]  bp_tab [5] = '{4'b1000, 4'b0100, 4'b0000, 4'b0010, 4'b0001};
    ci = 1'b1; cd = 1'b0; psr = 3'b000;
    for (int i = 0; i < 5; i++) begin
      ir_exec = ie_tab[i]; ir = ir_tab[i];
      byp_q.push_back(bp_tab[i]);
      #1;
      eb = byp_q.pop_front(); ab = byp(); n_total++;
      if (ab !== eb) $display("FAIL bypass[%0d] byp=%b required=%b", i, ab, eb);
      else begin n_pass++; $display("bypass[%0d] byp=%b", i, ab); end
    end
    ir = 16'h0000; ir_exec = 16'h1261;
    exp_q.push_back(8'b1111_1110);
    tick();
    e = exp_q.pop_front(); a = outs(); n_total++;
    if (a !== e) $display("FAIL add_wb outs=%b required=%b", a, e);
    else begin n_pass++; $display("add_wb outs=%b", a); end
    ir_exec = 16'h0000;
    exp_q.push_back(8'b1111_0110);
    tick();
    e = exp_q.pop_front(); a = outs(); n_total++;
    if (a !== e) $display("FAIL add_wb_end outs=%b required=%b", a, e);
    else begin n_pass++; $display("add_wb_end outs=%b", a); end
  endtask

  task automatic test_branch();
    logic [7:0] e, a;
    step_t s [9] = '{
      '{16'h0405, 3'b010, 1'b1, 1'b0, 8'b1100_0111},
      '{16'h0000, 3'b000, 1'b1, 1'b0, 8'b1100_0110},
      '{16'h0000, 3'b000, 1'b1, 1'b0, 8'b1111_0110},
      '{16'h0405, 3'b100, 1'b1, 1'b0, 8'b1111_0110},
      '{16'h0005, 3'b111, 1'b1, 1'b0, 8'b1111_0110},
      '{16'hC1C0, 3'b000, 1'b1, 1'b0, 8'b1100_0111},
      '{16'h0000, 3'b000, 1'b1, 1'b0, 8'b1100_0110},
      '{16'h0000, 3'b000, 1'b1, 1'b0, 8'b1111_0110},
      '{16'h0000, 3'b000, 1'b1, 1'b0, 8'b1111_0110}
    };
    for (int i = 0; i < 9; i++) begin
      ir_exec = s[i].ie; psr = s[i].psr; ci = s[i].ci; cd = s[i].cd;
      exp_q.push_back(s[i].exp);
      tick();
      e = exp_q.pop_front(); a = outs(); n_total++;
      if (a !== e) $display("FAIL branch[%0d] outs=%b required=%b", i, a, e);
      else begin n_pass++; $display("branch[%0d] outs=%b", i, a); end
    end
  endtask

  task automatic test_stall();
    logic [7:0] e, a;
    step_t s [8] = '{
      '{16'h0000, 3'b000, 1'b0, 1'b0, 8'b0000_0110},
      '{16'h0000, 3'b000, 1'b0, 1'b0, 8'b0000_0110},
      '{16'h0000, 3'b000, 1'b1, 1'b0, 8'b1111_0110},
      '{16'h0000, 3'b000, 1'b1, 1'b0, 8'b1111_0110},
      '{16'h0405, 3'b010, 1'b1, 1'b0, 8'b1100_0111},
      '{16'h0000, 3'b000, 1'b0, 1'b0, 8'b1100_0110},
      '{16'h0000, 3'b000, 1'b0, 1'b0, 8'b0000_0110},
      '{16'h0000, 3'b000, 1'b1, 1'b0, 8'b1111_0110}
    };
    for (int i = 0; i < 8; i++) begin
      ir_exec = s[i].ie; psr = s[i].psr; ci = s[i].ci; cd = s[i].cd;
      exp_q.push_back(s[i].exp);
      tick();
      e = exp_q.pop_front(); a = outs(); n_total++;
      if (a !== e) $display("FAIL stall[%0d] outs=%b required=%b", i, a, e);
      else begin n_pass++; $display("stall[%0d] outs=%b", i, a); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e, a;
    ci = 1'b1; cd = 1'b0; psr = 3'b000;
    ir_exec = 16'h6283;
    exp_q.push_back(8'b0000_0000);
    tick();
    e = exp_q.pop_front(); a = outs(); n_total++;
    if (a !== e) $display("FAIL mid_mem_enter outs=%b required=%b", a, e);
    else begin n_pass++; $display("mid_mem_enter outs=%b", a); end
    ir_exec = 16'h0000;
    #2;
    rst_n = 1'b0;
    exp_q.push_back(8'b0000_0110);
    #1;
    e = exp_q.pop_front(); a = outs(); n_total++;
    if (a !== e) $display("FAIL mid_mem_reset outs=%b required=%b", a, e);
    else begin n_pass++; $display("mid_mem_reset outs=%b", a); end
    exp_q.push_back(8'b0000_0110);
    tick();
    e = exp_q.pop_front(); a = outs(); n_total++;
    if (a !== e) $display("FAIL mid_mem_hold outs=%b required=%b", a, e);
    else begin n_pass++; $display("mid_mem_hold outs=%b", a); end
    rst_n = 1'b1;
    exp_q.push_back(8'b1100_0110);
    tick();
    e = exp_q.pop_front(); a = outs(); n_total++;
    if (a !== e) $display("FAIL refill outs=%b required=%b", a, e);
    else begin n_pass++; $display("refill outs=%b", a); end
    repeat (3) tick();
    ir_exec = 16'h0405; psr = 3'b010;
    exp_q.push_back(8'b1100_0111);
    tick();
    e = exp_q.pop_front(); a = outs(); n_total++;
    if (a !== e) $display("FAIL mid_flush_enter outs=%b required=%b", a, e);
    else begin n_pass++; $display("mid_flush_enter outs=%b", a); end
    ir_exec = 16'h0000; psr = 3'b000;
    #2;
    rst_n = 1'b0;
    exp_q.push_back(8'b0000_0110);
    #1;
    e = exp_q.pop_front(); a = outs(); n_total++;
    if (a !== e) $display("FAIL mid_flush_reset outs=%b required=%b", a, e);
    else begin n_pass++; $display("mid_flush_reset outs=%b", a); end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ldr();
    test_sti();
    test_bypass();
    test_branch();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

endmodule
